// File: rtl/note_pkg.sv
// Shared constants, colours and FSM state encoding for the note sprite plotter.
package note_pkg;

  localparam int DEF_NOTE_W   = 16;
  localparam int DEF_NOTE_H   = 4;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/note_xy_counter.sv
// Raster offset counter for the note sprite: dx inner, dy outer, with last-pixel flag.
module note_xy_counter
  import note_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int NOTE_H = DEF_NOTE_H
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [4:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [4:0] DX_MAX = 5'(NOTE_W - 1);
  localparam logic [3:0] DY_MAX = 4'(NOTE_H - 1);

  logic row_end;

  assign row_end = (dx == DX_MAX);
  assign last    = row_end && (dy == DY_MAX);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      dx <= 5'd0;
      dy <= 4'd0;
    end else if (enable) begin
      if (row_end) begin
        dx <= 5'd0;
        dy <= (dy == DY_MAX) ? 4'd0 : dy + 4'd1;
      end else begin
        dx <= dx + 5'd1;
      end
    end
  end

endmodule

// File: rtl/note_plotter.sv
// Plots (or erases) a NOTE_W x NOTE_H sprite one clipped pixel per cycle, then handshakes done.
// Define NOTE_OUTLINE_EN to draw the sprite border in white.
module note_plotter
  import note_pkg::*;
#(
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int NOTE_H   = DEF_NOTE_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go_draw,
  input  logic       go_erase,
  input  logic [8:0] origin_x,
  input  logic [7:0] origin_y,
  input  logic [2:0] draw_colour,
  output logic [8:0] plot_x,
  output logic [7:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       plot,
  output logic       done
);

  state_t     state;
  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [2:0] base_colour;
  logic       erase_mode;

  logic [4:0] dx;
  logic [3:0] dy;
  logic       last;
  logic       accept;
  logic       request;

  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic       visible;
  logic [2:0] pixel_colour;

  assign request = go_draw || go_erase;
  assign accept  = (state == IDLE) && request;

  note_xy_counter #(
    .NOTE_W(NOTE_W),
    .NOTE_H(NOTE_H)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .enable(state == PLOT),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  // Extra sum bit keeps sprites hanging off the right/bottom edge from wrapping on-screen.
  assign sum_x   = {1'b0, base_x} + {5'd0, dx};
  assign sum_y   = {1'b0, base_y} + {5'd0, dy};
  assign visible = (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));

  always_comb begin
    pixel_colour = base_colour;
    if (erase_mode) begin
      pixel_colour = COLOUR_BLACK;
    end
`ifdef NOTE_OUTLINE_EN
    else if ((dx == 5'd0) || (dx == 5'(NOTE_W - 1)) ||
             (dy == 4'd0) || (dy == 4'(NOTE_H - 1))) begin
      pixel_colour = COLOUR_WHITE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      base_x      <= 9'd0;
      base_y      <= 8'd0;
      base_colour <= 3'd0;
      erase_mode  <= 1'b0;
      plot        <= 1'b0;
      plot_x      <= 9'd0;
      plot_y      <= 8'd0;
      plot_colour <= 3'd0;
      done        <= 1'b0;
    end else begin
      plot        <= 1'b0;
      plot_x      <= 9'd0;
      plot_y      <= 8'd0;
      plot_colour <= 3'd0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            base_x      <= origin_x;
            base_y      <= origin_y;
            base_colour <= draw_colour;
            erase_mode  <= go_erase;
            state       <= PLOT;
          end
        end
        PLOT: begin
          plot        <= visible;
          plot_x      <= sum_x[8:0];
          plot_y      <= sum_y[7:0];
          plot_colour <= pixel_colour;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (!request) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
